// File: rtl/fc_port_link.sv
// 8GFC port link layer: link init FSM (OLS/LR/LRR/Idle), idle fill and frame TX/RX over a 32-bit 8b/10b PCS word.
// One cycle sink->PCS and PCS->source; sink held off outside AC, in the post-EOF idle gap and on the cycle AC is left.
module fc_port_link #(
    parameter int MIN_IDLES = 2,
    parameter int OS_MATCH  = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tx_ready,
    input  logic        rx_ready,
    input  logic        rx_syncstatus,
    output logic [31:0] phy_tx_data,
    output logic [3:0]  phy_tx_datak,
    input  logic [31:0] phy_rx_data,
    input  logic [3:0]  phy_rx_datak,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sop,
    input  logic        in_eop,
    output logic [31:0] out_data,
    output logic        out_valid,
    output logic        out_sop,
    output logic        out_eop,
    output logic [3:0]  state
);
    localparam logic [31:0] OS_IDLE = 32'hBC95B5B5;
    localparam logic [31:0] OS_LR   = 32'hBC49BF49;
    localparam logic [31:0] OS_LRR  = 32'hBC35BF49;
    localparam logic [31:0] OS_NOS  = 32'hBC55BF45;
    localparam logic [31:0] OS_OLS  = 32'hBC358A55;
    localparam logic [3:0]  K_OS    = 4'b1000;
    localparam int CW = $clog2(OS_MATCH + 1);
    localparam int GW = $clog2(MIN_IDLES + 1);

    typedef enum logic [3:0] {
        LF2 = 4'd0, OL1 = 4'd1, LR1 = 4'd2, LR2 = 4'd3, LR3 = 4'd4, AC = 4'd5
    } state_t;

    state_t          state_q, state_d;
    logic [31:0]     os_last_q;
    logic [CW-1:0]   os_run_q, os_run_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic [31:0]     tx_data_q, tx_data_d;
    logic [3:0]      tx_datak_q, tx_datak_d;
    logic            in_frame_q, in_frame_d;
    logic [31:0]     out_data_q;
    logic            out_valid_q, out_valid_d;
    logic            out_sop_q, out_sop_d;
    logic            out_eop_q, out_eop_d;

    logic link_up, rx_os, os_hit, accept;
    logic hit_idle, hit_lr, hit_lrr, hit_nos, hit_ols;
    logic rx_ac, rx_delim, rx_eof, rx_sof;

    assign link_up = tx_ready & rx_ready & rx_syncstatus;
    assign rx_os   = (phy_rx_datak == K_OS);

    // Length of the current run of identical ordered sets, saturating at OS_MATCH.
    always_comb begin
        os_run_d = '0;
        if (rx_os) begin
            if ((phy_rx_data == os_last_q) && (os_run_q != '0))
                os_run_d = (os_run_q == CW'(OS_MATCH)) ? os_run_q : os_run_q + 1'b1;
            else
                os_run_d = CW'(1);
        end
    end

    assign os_hit   = (os_run_d == CW'(OS_MATCH));
    assign hit_idle = os_hit && (phy_rx_data == OS_IDLE);
    assign hit_lr   = os_hit && (phy_rx_data == OS_LR);
    assign hit_lrr  = os_hit && (phy_rx_data == OS_LRR);
    assign hit_nos  = os_hit && (phy_rx_data == OS_NOS);
    assign hit_ols  = os_hit && (phy_rx_data == OS_OLS);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= LF2;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (!link_up) begin
            state_d = LF2;
        end else begin
            case (state_q)
                LF2: state_d = OL1;
                OL1: if (hit_ols) state_d = LR1; else if (hit_lr) state_d = LR2;
                LR1: if (hit_lr) state_d = LR2; else if (hit_lrr) state_d = LR3;
                LR2: if (hit_lrr || hit_idle) state_d = LR3;
                LR3: if (hit_idle) state_d = AC; else if (hit_lr) state_d = LR2;
                AC:  if (hit_lr) state_d = LR2; else if (hit_ols) state_d = LR1;
                     else if (hit_nos) state_d = OL1;
                default: state_d = LF2;
            endcase
        end
    end

    // in_ready also looks at state_d so no word is accepted on the cycle the link leaves AC.
    always_comb begin
        in_ready   = (state_q == AC) && (state_d == AC) && (gap_q == '0);
        accept     = in_valid && in_ready;
        tx_data_d  = OS_NOS;
        tx_datak_d = K_OS;
        gap_d      = '0;
        case (state_d)
            LF2: tx_data_d = OS_NOS;
            OL1: tx_data_d = OS_OLS;
            LR1: tx_data_d = OS_LR;
            LR2: tx_data_d = OS_LRR;
            LR3: tx_data_d = OS_IDLE;
            AC: begin
                gap_d = (gap_q != '0) ? gap_q - 1'b1 : '0;
                if (accept) begin
                    tx_data_d  = in_data;
                    tx_datak_d = (in_sop || in_eop) ? K_OS : 4'b0000;
                    if (in_eop) gap_d = GW'(MIN_IDLES);
                end else begin
                    tx_data_d = OS_IDLE;
                end
            end
            default: tx_data_d = OS_NOS;
        endcase
    end

    // Delimiters share K28.5 + D21.4/D21.5 with Idle; EOFs carry D21.3/D21.6/D21.7 in the third byte.
    assign rx_ac    = (state_q == AC) && (state_d == AC);
    assign rx_delim = rx_os && (phy_rx_data[31:24] == 8'hBC) &&
                      ((phy_rx_data[23:16] == 8'h95) || (phy_rx_data[23:16] == 8'hB5)) &&
                      (phy_rx_data != OS_IDLE);
    assign rx_eof   = rx_delim && ((phy_rx_data[15:8] == 8'h75) || (phy_rx_data[15:8] == 8'hD5) ||
                                   (phy_rx_data[15:8] == 8'hF5));
    assign rx_sof   = rx_delim && !rx_eof;

    always_comb begin
        out_valid_d = 1'b0;
        out_sop_d   = 1'b0;
        out_eop_d   = 1'b0;
        in_frame_d  = in_frame_q;
        if (!rx_ac) begin
            in_frame_d = 1'b0;
        end else if (rx_sof) begin
            out_valid_d = 1'b1;
            out_sop_d   = 1'b1;
            in_frame_d  = 1'b1;
        end else if (in_frame_q && (phy_rx_datak == 4'b0000)) begin
            out_valid_d = 1'b1;
        end else if (in_frame_q && rx_eof) begin
            out_valid_d = 1'b1;
            out_eop_d   = 1'b1;
            in_frame_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            os_last_q   <= '0;
            os_run_q    <= '0;
            gap_q       <= '0;
            tx_data_q   <= OS_NOS;
            tx_datak_q  <= K_OS;
            in_frame_q  <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
        end else begin
            os_last_q   <= phy_rx_data;
            os_run_q    <= os_run_d;
            gap_q       <= gap_d;
            tx_data_q   <= tx_data_d;
            tx_datak_q  <= tx_datak_d;
            in_frame_q  <= in_frame_d;
            out_data_q  <= phy_rx_data;
            out_valid_q <= out_valid_d;
            out_sop_q   <= out_sop_d;
            out_eop_q   <= out_eop_d;
        end
    end

    assign phy_tx_data  = tx_data_q;
    assign phy_tx_datak = tx_datak_q;
    assign out_data     = out_data_q;
    assign out_valid    = out_valid_q;
    assign out_sop      = out_sop_q;
    assign out_eop      = out_eop_q;
    assign state        = state_q;

endmodule

// File: tb/tb_fc_port_link.sv
// Bench for fc_port_link: a cycle-level reference model of the link rules checks every output each cycle,
// driven by directed link/frame scenarios and randomized ordered-set, link-drop and frame traffic.
module tb_fc_port_link;
    localparam int          MIN_IDLES = 2;
    localparam logic [31:0] IDLE = 32'hBC95B5B5;
    localparam logic [31:0] LR   = 32'hBC49BF49;
    localparam logic [31:0] LRR  = 32'hBC35BF49;
    localparam logic [31:0] NOS  = 32'hBC55BF45;
    localparam logic [31:0] OLS  = 32'hBC358A55;
    localparam logic [31:0] SOF  = 32'hBCB55656;
    localparam logic [31:0] EOF  = 32'hBC957575;

    logic        clk = 1'b0;
    logic        reset;
    logic        tx_ready, rx_ready, rx_syncstatus;
    logic [31:0] phy_tx_data, phy_rx_data, in_data, out_data;
    logic [3:0]  phy_tx_datak, phy_rx_datak, state;
    logic        in_valid, in_ready, in_sop, in_eop;
    logic        out_valid, out_sop, out_eop;

    logic        lb;
    logic [31:0] rx_drv_d;
    logic [3:0]  rx_drv_k;

    always #5 clk = ~clk;

    assign phy_rx_data  = lb ? phy_tx_data  : rx_drv_d;
    assign phy_rx_datak = lb ? phy_tx_datak : rx_drv_k;

    fc_port_link #(.MIN_IDLES(MIN_IDLES), .OS_MATCH(3)) dut (
        .clk(clk), .reset(reset),
        .tx_ready(tx_ready), .rx_ready(rx_ready), .rx_syncstatus(rx_syncstatus),
        .phy_tx_data(phy_tx_data), .phy_tx_datak(phy_tx_datak),
        .phy_rx_data(phy_rx_data), .phy_rx_datak(phy_rx_datak),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .in_sop(in_sop), .in_eop(in_eop),
        .out_data(out_data), .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop),
        .state(state)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Reference model state
    int          m_st;
    logic [31:0] m_tx, m_od;
    logic [3:0]  m_txk;
    int          m_idles;
    logic [35:0] m_hist[$];
    bit          m_fr, m_ov, m_osop, m_oeop;

    logic [33:0] txq[$];
    int          stall_pct;
    int          mon_ovld, mon_sop, mon_eop;
    bit          gap_on;
    int          gap_run, last_gap;

    function automatic logic [31:0] st_os(input int s);
        case (s)
            0: return NOS;
            1: return OLS;
            2: return LR;
            3: return LRR;
            default: return IDLE;
        endcase
    endfunction

    task automatic push_frame(input int n);
        txq.push_back({1'b1, 1'b0, SOF});
        for (int i = 0; i < n; i++) txq.push_back({2'b00, 32'($urandom)});
        txq.push_back({1'b0, 1'b1, EOF});
    endtask

    // One clock: drive the sink, check all outputs against the model, advance the model.
    task automatic cyc();
        logic [31:0] rd;
        logic [3:0]  rk;
        bit          hit, rdy, acc, lu;
        int          nst;
        if (txq.size() > 0 && $urandom_range(99) >= stall_pct) begin
            in_valid = 1'b1;
            {in_sop, in_eop, in_data} = txq[0];
        end else begin
            in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_data = $urandom;
        end
        #1;
        rd = lb ? m_tx  : rx_drv_d;
        rk = lb ? m_txk : rx_drv_k;
        m_hist.push_back({rk, rd});
        if (m_hist.size() > 3) void'(m_hist.pop_front());
        hit = (m_hist.size() == 3);
        foreach (m_hist[i]) if (m_hist[i] !== {4'b1000, rd}) hit = 1'b0;
        lu  = tx_ready & rx_ready & rx_syncstatus;
        nst = m_st;
        if (!lu) nst = 0;
        else case (m_st)
            0: nst = 1;
            1: if (hit && rd == OLS) nst = 2; else if (hit && rd == LR) nst = 3;
            2: if (hit && rd == LR) nst = 3; else if (hit && rd == LRR) nst = 4;
            3: if (hit && (rd == LRR || rd == IDLE)) nst = 4;
            4: if (hit && rd == IDLE) nst = 5; else if (hit && rd == LR) nst = 3;
            default: if (hit && rd == LR) nst = 3; else if (hit && rd == OLS) nst = 2;
                     else if (hit && rd == NOS) nst = 1;
        endcase
        rdy = (m_st == 5) && (nst == 5) && (m_idles >= MIN_IDLES);

        chk("state",     32'(state), 32'(m_st));
        chk("tx_data",   phy_tx_data, m_tx);
        chk("tx_datak",  32'(phy_tx_datak), 32'(m_txk));
        chk("in_ready",  32'(in_ready), 32'(rdy));
        chk("out_valid", 32'(out_valid), 32'(m_ov));
        if (m_ov) begin
            chk("out_data", out_data, m_od);
            chk("out_sop",  32'(out_sop), 32'(m_osop));
            chk("out_eop",  32'(out_eop), 32'(m_oeop));
        end

        if (out_valid) mon_ovld++;
        if (out_valid && out_sop) mon_sop++;
        if (out_valid && out_eop) mon_eop++;
        if (phy_tx_data == EOF && phy_tx_datak == 4'b1000) begin
            gap_on = 1'b1; gap_run = 0;
        end else if (gap_on && phy_tx_data == IDLE && phy_tx_datak == 4'b1000) begin
            gap_run++;
        end else if (gap_on && phy_tx_data == SOF && phy_tx_datak == 4'b1000) begin
            last_gap = gap_run; gap_on = 1'b0;
        end

        acc = in_valid && rdy;
        m_ov = 1'b0; m_osop = 1'b0; m_oeop = 1'b0; m_od = rd;
        if (m_st == 5 && nst == 5) begin
            if (rk == 4'b1000 && rd == SOF) begin m_ov = 1'b1; m_osop = 1'b1; m_fr = 1'b1; end
            else if (m_fr && rk == 4'b0000) m_ov = 1'b1;
            else if (m_fr && rk == 4'b1000 && rd == EOF) begin m_ov = 1'b1; m_oeop = 1'b1; m_fr = 1'b0; end
        end else begin
            m_fr = 1'b0;
        end
        if (nst != 5) begin
            m_tx = st_os(nst); m_txk = 4'b1000; m_idles = MIN_IDLES;
        end else if (acc) begin
            m_tx = in_data; m_txk = (in_sop || in_eop) ? 4'b1000 : 4'b0000;
            if (in_eop) m_idles = 0;
        end else begin
            m_tx = IDLE; m_txk = 4'b1000;
            if (m_idles < MIN_IDLES) m_idles++;
        end
        m_st = nst;
        if (acc) void'(txq.pop_front());
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic bring_up(input string tag);
        for (int i = 0; i < 80 && state != 4'd5; i++) cyc();
        chk(tag, 32'(state), 32'd5);
    endtask

    logic [31:0] seq[$];
    logic [31:0] exp_seq [5];
    logic [31:0] sv;
    int          rx_run;

    initial begin
        exp_seq = '{NOS, OLS, LR, LRR, IDLE};
        reset = 1'b1; tx_ready = 1'b0; rx_ready = 1'b0; rx_syncstatus = 1'b0;
        lb = 1'b0; rx_drv_d = IDLE; rx_drv_k = 4'b1000;
        in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_data = '0;
        stall_pct = 0; mon_ovld = 0; mon_sop = 0; mon_eop = 0;
        gap_on = 1'b0; gap_run = 0; last_gap = -1; rx_run = 0;
        m_st = 0; m_tx = NOS; m_txk = 4'b1000; m_idles = MIN_IDLES;
        m_fr = 1'b0; m_ov = 1'b0; m_osop = 1'b0; m_oeop = 1'b0; m_od = '0;

        repeat (2) @(negedge clk);
        chk("rst_state",    32'(state), 32'd0);
        chk("rst_tx",       phy_tx_data, NOS);
        chk("rst_txk",      32'(phy_tx_datak), 32'h8);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_vld",  32'(out_valid), 32'd0);
        reset = 1'b0;
        repeat (3) cyc();

        // Loopback link initialisation
        lb = 1'b1; tx_ready = 1'b1; rx_ready = 1'b1; rx_syncstatus = 1'b1;
        seq.push_back(phy_tx_data);
        for (int i = 0; i < 80 && state != 4'd5; i++) begin
            cyc();
            if (phy_tx_data != seq[$]) seq.push_back(phy_tx_data);
        end
        chk("init_ac", 32'(state), 32'd5);
        chk("init_seq_len", 32'(seq.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            sv = (i < seq.size()) ? seq[i] : 32'h0;
            chk("init_seq", sv, exp_seq[i]);
        end
        repeat (4) cyc();

        // Directed frame: SOFi3, ten zero words, EOFt
        mon_ovld = 0; mon_sop = 0; mon_eop = 0;
        txq.push_back({1'b1, 1'b0, SOF});
        for (int i = 0; i < 10; i++) txq.push_back({2'b00, 32'h0});
        txq.push_back({1'b0, 1'b1, EOF});
        repeat (25) cyc();
        chk("frame_words", 32'(mon_ovld), 32'd12);
        chk("frame_sop",   32'(mon_sop),  32'd1);
        chk("frame_eop",   32'(mon_eop),  32'd1);

        // Back-to-back frames
        push_frame(3);
        push_frame(2);
        last_gap = -1;
        for (int i = 0; i < 60 && txq.size() > 0; i++) cyc();
        repeat (6) cyc();
        chk("b2b_idle_gap", 32'(last_gap), 32'd2);

        // Sync loss mid-frame, then relink
        push_frame(8);
        repeat (4) cyc();
        rx_syncstatus = 1'b0;
        cyc();
        rx_syncstatus = 1'b1;
        txq.delete();
        #1;
        chk("drop_state",    32'(state), 32'd0);
        chk("drop_tx",       phy_tx_data, NOS);
        chk("drop_in_ready", 32'(in_ready), 32'd0);
        bring_up("relink_ac");
        repeat (4) cyc();

        // Received LR: two is not enough, three forces LR2
        lb = 1'b0; rx_drv_d = IDLE; rx_drv_k = 4'b1000;
        repeat (3) cyc();
        rx_drv_d = LR; repeat (2) cyc();
        rx_drv_d = IDLE; repeat (2) cyc();
        chk("lr2x_stay_ac", 32'(state), 32'd5);
        rx_drv_d = LR; repeat (3) cyc();
        chk("lr3x_state", 32'(state), 32'd3);
        chk("lr3x_tx",    phy_tx_data, LRR);

        // Randomized traffic: ordered-set runs, link drops, loopback segments, frames
        stall_pct = 30;
        for (int n = 0; n < 2500; n++) begin
            if (n % 250 == 0) lb = ($urandom_range(9) < 6);
            if (rx_run == 0) begin
                rx_drv_k = 4'b1000;
                case ($urandom_range(9))
                    0: rx_drv_d = LR;
                    1: rx_drv_d = LRR;
                    2: rx_drv_d = NOS;
                    3: rx_drv_d = OLS;
                    4, 5: rx_drv_d = IDLE;
                    6: rx_drv_d = SOF;
                    7: rx_drv_d = EOF;
                    8: begin rx_drv_d = $urandom; rx_drv_k = 4'b0000; end
                    default: begin rx_drv_d = $urandom; rx_drv_k = 4'($urandom_range(15)); end
                endcase
                rx_run = $urandom_range(1, 4);
            end
            rx_run--;
            rx_syncstatus = ($urandom_range(199) != 0);
            if (txq.size() < 3 && $urandom_range(9) == 0) push_frame($urandom_range(0, 6));
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
